// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the bridge: IDLE -> GRANT (bus cycle) -> RESP (ack).
// Define ARB_LOCK_EN to add per-master lock inputs that hold ownership across transactions.
module bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_from_cpu,
   input  logic              rst_from_cpu,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
`ifdef ARB_LOCK_EN
   input  logic              m0_lock,
   input  logic              m1_lock,
`endif
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] addr_to_bridge,
   output logic              we_to_bridge,
   output logic [DATA_W-1:0] wdata_to_bridge,
   input  logic [DATA_W-1:0] rdata_from_bridge,
   output logic              owner
);

   typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

   state_t            state_reg, state_next;
   logic              owner_reg, owner_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic              we_reg, we_next;
   logic [DATA_W-1:0] wdata_reg, wdata_next;
   logic              locked_reg, locked_next;
   logic [DATA_W-1:0] rdata0_reg, rdata1_reg;
   logic              elig0, elig1;
   logic              grant_idx;

   // While locked, only the current owner's request is visible to arbitration.
   always_comb begin
      elig0 = m0_req && (!locked_reg || !owner_reg);
      elig1 = m1_req && (!locked_reg || owner_reg);
   end

   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      addr_next   = addr_reg;
      we_next     = we_reg;
      wdata_next  = wdata_reg;
      locked_next = locked_reg;
      grant_idx   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (elig0 && elig1) grant_idx = ~owner_reg;
            else                grant_idx = elig1;
            if (elig0 || elig1) begin
               state_next = GRANT;
               owner_next = grant_idx;
               addr_next  = grant_idx ? m1_addr  : m0_addr;
               we_next    = grant_idx ? m1_we    : m0_we;
               wdata_next = grant_idx ? m1_wdata : m0_wdata;
            end
         end
         GRANT: state_next = RESP;
         RESP: begin
            state_next = IDLE;
`ifdef ARB_LOCK_EN
            locked_next = owner_reg ? m1_lock : m0_lock;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_from_cpu) begin
      if (rst_from_cpu) begin
         state_reg  <= IDLE;
         owner_reg  <= 1'b1;
         addr_reg   <= '0;
         we_reg     <= 1'b0;
         wdata_reg  <= '0;
         locked_reg <= 1'b0;
         rdata0_reg <= '0;
         rdata1_reg <= '0;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         addr_reg   <= addr_next;
         we_reg     <= we_next;
         wdata_reg  <= wdata_next;
         locked_reg <= locked_next;
         // Captured for writes as well; the value is simply ignored by the master.
         if (state_reg == GRANT) begin
            if (owner_reg) rdata1_reg <= rdata_from_bridge;
            else           rdata0_reg <= rdata_from_bridge;
         end
      end
   end

   always_comb begin
      addr_to_bridge  = (state_reg == GRANT) ? addr_reg  : '0;
      we_to_bridge    = (state_reg == GRANT) ? we_reg    : 1'b0;
      wdata_to_bridge = (state_reg == GRANT) ? wdata_reg : '0;
      m0_ack          = (state_reg == RESP) && !owner_reg;
      m1_ack          = (state_reg == RESP) && owner_reg;
      m0_rdata        = rdata0_reg;
      m1_rdata        = rdata1_reg;
      owner           = owner_reg;
   end

endmodule
